// File: rtl/signdet_score_streamer.sv
// Streams NUM_CLASS class scores from the CNN result RAM as an init pulse plus a contiguous write burst.
// Latency: o_init one cycle after i_start, first beat RD_LAT+2 cycles after o_init; no backpressure, i_abort cancels.
module signdet_score_streamer #(
  parameter int NUM_CLASS = 7,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [15:0]       i_rd_data,
  output logic              o_init,
  output logic              o_we,
  output logic [15:0]       o_dout,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {IDLE, INIT, READ, DRAIN, DONE} state_t;

  localparam logic [3:0]        LAST = 4'(NUM_CLASS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state, state_nxt;
  logic [3:0]        rd_cnt, rd_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              rd_en_nxt;
  logic [RD_LAT-1:0] vpipe;
  logic              vout;

  assign vout = vpipe[RD_LAT-1];

  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    addr_nxt   = o_rd_addr;
    rd_en_nxt  = 1'b0;
    case (state)
      IDLE: if (i_start) state_nxt = INIT;
      INIT: begin
        state_nxt  = READ;
        rd_en_nxt  = 1'b1;
        addr_nxt   = BASE;
        rd_cnt_nxt = 4'd0;
      end
      READ: begin
        if (rd_cnt == LAST) begin
          state_nxt = DRAIN;
        end else begin
          rd_en_nxt  = 1'b1;
          addr_nxt   = o_rd_addr + ADDR_W'(1);
          rd_cnt_nxt = rd_cnt + 4'd1;
        end
      end
      // The last beat is on o_we while the pipeline has just emptied.
      DRAIN: if (vpipe == '0 && o_we) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_abort) begin
      state_nxt = IDLE;
      rd_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rd_cnt    <= 4'd0;
      o_rd_addr <= '0;
      o_rd_en   <= 1'b0;
      o_init    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_we      <= 1'b0;
      o_dout    <= 16'd0;
      vpipe     <= '0;
    end else begin
      state     <= state_nxt;
      rd_cnt    <= rd_cnt_nxt;
      o_rd_addr <= addr_nxt;
      o_rd_en   <= rd_en_nxt;
      o_init    <= (state_nxt == INIT);
      o_busy    <= (state_nxt != IDLE);
      o_done    <= (state_nxt == DONE);
      // Abort drops in-flight reads so a stale score can never surface later.
      if (i_abort) begin
        vpipe <= '0;
        o_we  <= 1'b0;
      end else begin
        vpipe[0] <= o_rd_en;
        for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
        o_we <= vout;
        if (vout) o_dout <= i_rd_data;
      end
    end
  end

endmodule
